// File: rtl/cory_unpack_seq_pkg.sv
// Shared definitions for the cory_unpack_seq sequencer: state encoding,
// a constant clog2 helper and the field-slice macro used to pick field k
// out of a packed word of n-bit fields.
`ifndef CORY_UNPACK_SEQ_PKG_SV
`define CORY_UNPACK_SEQ_PKG_SV

// Field k of a packed word built from n-bit fields.
`define CORY_FIELD(k, n) (k)*(n) +: (n)

package cory_unpack_seq_pkg;

    // IDLE: no word held. SEND: a word with a nonzero pending mask is held.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Ceiling log2, at least 1 so that a one-bit index is always available.
    function automatic int cory_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/cory_pri_enc.sv
// Combinational priority encoder over a field mask. With MSB=0 the lowest
// set bit wins, with MSB=1 the highest. Produces the winning index, its
// one-hot form and a flag that is set when exactly one mask bit is set.
module cory_pri_enc #(
    parameter int F   = 16,
    parameter int IW  = 4,
    parameter bit MSB = 1'b0
) (
    input  logic [F-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic [F-1:0]  onehot_o,
    output logic          single_o
);

    // Scanning the mask in priority order: for MSB-first the mask is
    // bit-reversed so the same lowest-set-bit trick serves both orders.
    logic [F-1:0] scan_mask;
    logic [F-1:0] scan_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < F; gi = gi + 1) begin : g_order
            if (MSB) begin : g_rev
                assign scan_mask[gi] = mask_i[F-1-gi];
                assign onehot_o[gi]  = scan_onehot[F-1-gi];
            end else begin : g_fwd
                assign scan_mask[gi] = mask_i[gi];
                assign onehot_o[gi]  = scan_onehot[gi];
            end
        end
    endgenerate

    // Isolating the lowest set bit of the scan-ordered mask.
    assign scan_onehot = scan_mask & (~scan_mask + {{(F-1){1'b0}}, 1'b1});

    // Exactly one bit set: nonzero and clearing the lowest bit leaves zero.
    assign single_o = (mask_i != '0) &&
                      ((mask_i & (mask_i - {{(F-1){1'b0}}, 1'b1})) == '0);

    // Converting the one-hot winner into a binary index.
    always_comb begin
        idx_o = '0;
        for (int k = 0; k < F; k++) begin
            if (onehot_o[k]) begin
                idx_o = idx_o | IW'(k);
            end
        end
    end

endmodule

// File: rtl/cory_unpack_seq.sv
// Sequencer that unpacks a word of F fields of N bits onto a single narrow
// valid/ready channel, one enabled field per handshake, tagged with its
// index and a last flag. Fields are emitted lowest index first; defining
// CORY_UNPACK_SEQ_MSB_FIRST_EN reverses this to highest index first.
import cory_unpack_seq_pkg::*;

module cory_unpack_seq #(
    parameter int N  = 8,
    parameter int F  = 16,
    parameter int A  = N*F,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_a_v,
    input  logic [A-1:0]  i_a_d,
    input  logic [F-1:0]  i_a_m,
    output logic          o_a_r,
    output logic          o_z_v,
    output logic [N-1:0]  o_z_d,
    output logic [IW-1:0] o_z_i,
    output logic          o_z_l,
    input  logic          i_z_r
);

    localparam int SELW = cory_clog2(F);

`ifdef CORY_UNPACK_SEQ_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    state_e       state_q, state_d;
    logic [F-1:0] mask_q,  mask_d;
    logic [A-1:0] data_q,  data_d;

    logic [SELW-1:0] sel;
    logic [F-1:0]    sel_onehot;
    logic            sel_single;

    logic z_v;
    logic a_r;
    logic z_fire;
    logic a_accept;

    cory_pri_enc #(
        .F   (F),
        .IW  (SELW),
        .MSB (MSB_FIRST)
    ) u_pri_enc (
        .mask_i   (mask_q),
        .idx_o    (sel),
        .onehot_o (sel_onehot),
        .single_o (sel_single)
    );

    // State, pending mask and held word; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

    // Output drive and next-state: emit the selected field, retire it on
    // handshake, and reload in the same cycle as the last beat for
    // back-to-back words.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        o_z_d   = '0;
        o_z_i   = '0;
        o_z_l   = 1'b0;

        z_v = (state_q == SEND);
        if (z_v) begin
            o_z_d = data_q[`CORY_FIELD(sel, N)];
            o_z_i = IW'(sel);
            o_z_l = sel_single;
        end

        // Ready never looks at i_a_v, only at the downstream handshake.
        a_r      = (state_q == IDLE) | (z_v & i_z_r & sel_single);
        z_fire   = z_v & i_z_r;
        a_accept = i_a_v & a_r;

        if (z_fire) begin
            mask_d = mask_q & ~sel_onehot;
            if (sel_single) begin
                state_d = IDLE;
            end
        end

        if (a_accept) begin
            if (i_a_m != '0) begin
                mask_d  = i_a_m;
                data_d  = i_a_d;
                state_d = SEND;
            end else begin
                state_d = IDLE;
            end
        end

        o_z_v = z_v;
        o_a_r = a_r;
    end

endmodule

// File: doc/cory_unpack_seq.md
Name: cory_unpack_seq

Overview:
- Sequencer that walks a packed word of F equal-width fields onto one narrow valid/ready output channel, one field per handshake.
- Each word carries a field-enable mask; only enabled fields are emitted, in ascending index order, tagged with their index and a last flag.
- Sits between a wide packed producer and a single shared narrow consumer, replacing a fan-out unpack where downstream has only one port.

Parameters:
- N, 8, field width in bits
- F, 16, number of fields per word (2..64)
- A, N*F, packed word width; field k occupies bits [k*N +: N]
- IW, 4, field index width; must be at least clog2(F)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous reset, active-high
- i_a_v  in  1  packed word valid
- i_a_d  in  A  packed word
- i_a_m  in  F  field-enable mask; bit k enables field k
- o_a_r  out  1  packed word ready
- o_z_v  out  1  field valid
- o_z_d  out  N  field data
- o_z_i  out  IW  index of the field being emitted
- o_z_l  out  1  last enabled field of the current word
- i_z_r  in  1  field ready

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE, held mask=0, held data=0. Outputs next cycle: o_z_v=0, o_z_d=0, o_z_i=0, o_z_l=0, o_a_r=1.
- Reset mid-word drops the remaining fields with no partial flush. Reset dominates any simultaneous handshake.
- States:
  - IDLE: no word held.
  - SEND: a word is held with a nonzero pending mask.
- Input accept: occurs when i_a_v & o_a_r.
  - o_a_r = (state==IDLE) | (o_z_v & i_z_r & o_z_l).
  - This gives back-to-back words with no bubble.
  - o_a_r depends combinationally on i_z_r; it never depends on i_a_v.
- On accept with i_a_m != 0: latch i_a_d and i_a_m, go to SEND. o_z_v rises the following cycle (latency 1).
- On accept with i_a_m == 0: the word is consumed and nothing is emitted. State becomes or stays IDLE.
- In SEND:
  - o_z_v=1.
  - sel = lowest set bit of the pending mask.
  - o_z_d = held field sel; o_z_i = sel.
  - o_z_l=1 iff the pending mask has exactly one bit set.
- On output handshake (o_z_v & i_z_r): clear bit sel in the pending mask.
  - If o_z_l: go to IDLE, unless a new word is accepted in the same cycle, in which case reload and stay in SEND.
- Stall: while o_z_v & !i_z_r, all outputs are held stable. Valid never drops without a handshake.
- Throughput: one field per cycle. A word with P enabled fields occupies P cycles.
- i_a_d and i_a_m are sampled only at accept. Changes while o_a_r=0 are ignored.
- Fields with mask bit 0 are never emitted, whatever their data.
- o_z_i is zero-extended when IW > clog2(F).

Optional Feature:
- Macro: CORY_UNPACK_SEQ_MSB_FIRST_EN.
- Defined: sel = highest set bit of the pending mask, so fields are emitted in descending index order. o_z_l is unchanged (one bit remaining).
- Undefined: ascending order, as above.
- Data, index and handshake semantics are otherwise identical.

Decomposition:
- Shared package/include: clog2 constant function, the field-slice macro (k*N +: N), and state encodings IDLE=1'b0 / SEND=1'b1.
- One natural sub-module: cory_pri_enc #(F, IW, MSB). It is combinational: mask in -> index, one-hot, and a single-bit flag.
- The sequencer instantiates it once. The macro selects the MSB parameter.

Test Plan:
- N=8, F=4; word 0x44332211, mask 4'b1111, i_z_r=1 -> four beats (i,d) = (0,11) (1,22) (2,33) (3,44), l=1 only on the 4th, then o_a_r=1.
- Mask 4'b1010, data 0xDDCCBBAA -> beats (1,BB) then (3,DD,l=1); fields 0 and 2 never appear.
- Mask 0 with i_a_v=1 -> o_a_r stays 1, no o_z_v pulse. A word with mask 4'b0001 the next cycle -> single beat (0,d0,l=1).
- Backpressure: i_z_r=0 for 5 cycles during beat 2 -> o_z_v/d/i/l frozen, o_a_r=0. Release -> sequence resumes with no loss or duplicate.
- Back-to-back: second word valid during the last beat of the first -> accepted in the same cycle; its first beat is on the next cycle with no idle gap.
- reset=1 during beat 1 of 4 -> next cycle o_z_v=0, o_a_r=1; the remaining fields are never emitted. With CORY_UNPACK_SEQ_MSB_FIRST_EN, mask 4'b1111 -> index order 3,2,1,0.
